conv1_pe_8b: RTL

CONV1_PE_8B -- requirements
Module: conv1_pe_8b

---
 rtl/conv1_pe_8b.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/conv1_pe_8b.sv
// conv1_pe_8b: 3x3 convolution processing element with 8-bit signed weights,
//   bias add, ReLU, requantising arithmetic shift and saturation to 8 bits.
// Latency: window presented in the cycle before edge N appears on valid_out after edge N+2
//   (three registered stages); one window per cycle, no backpressure (dropped unless READY).
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   wload_en / wload_data     : weight load beats, w0..w8 then bias (signed bytes)
//   valid_in / pixel_0..8     : unsigned 3x3 window, row-major, pixel_0 top-left
//   weights_ready             : high while a complete weight set is held and no load is active
//   valid_out / pixel_out     : one-cycle result strobe and requantised ReLU pixel (0 when idle)
module conv1_pe_8b #(
  parameter int SHIFT   = 4,
  parameter int NUM_PIX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wload_en,
  input  logic [7:0] wload_data,
  input  logic       valid_in,
  input  logic [7:0] pixel_0,
  input  logic [7:0] pixel_1,
  input  logic [7:0] pixel_2,
  input  logic [7:0] pixel_3,
  input  logic [7:0] pixel_4,
  input  logic [7:0] pixel_5,
  input  logic [7:0] pixel_6,
  input  logic [7:0] pixel_7,
  input  logic [7:0] pixel_8,
  output logic       weights_ready,
  output logic       valid_out,
  output logic [7:0] pixel_out
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             count_q, count_d;
  logic signed [7:0]      w_q [NUM_PIX];
  logic signed [7:0]      w_d [NUM_PIX];
  logic signed [7:0]      bias_q, bias_d;

  logic [7:0]             pix [NUM_PIX];

  logic signed [16:0]     prod_q [NUM_PIX];
  logic signed [16:0]     prod_d [NUM_PIX];
  logic signed [7:0]      bias1_q, bias1_d;
  logic                   v1_q, v1_d;

  logic signed [20:0]     sum_q, sum_d;
  logic                   v2_q, v2_d;

  logic [7:0]             pixel_out_q, pixel_out_d;
  logic                   valid_out_q, valid_out_d;

  logic                   accept;
  logic signed [20:0]     shifted;

  assign pix[0] = pixel_0;
  assign pix[1] = pixel_1;
  assign pix[2] = pixel_2;
  assign pix[3] = pixel_3;
  assign pix[4] = pixel_4;
  assign pix[5] = pixel_5;
  assign pix[6] = pixel_6;
  assign pix[7] = pixel_7;
  assign pix[8] = pixel_8;

  assign weights_ready = (state_q == ST_READY);
  assign accept        = valid_in && (state_q == ST_READY);
  assign valid_out     = valid_out_q;
  assign pixel_out     = pixel_out_q;

  // Weight-load FSM. A beat outside LOADING always restarts the load at w0.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    bias_d  = bias_q;
    for (int i = 0; i < NUM_PIX; i++) w_d[i] = w_q[i];

    if (wload_en) begin
      case (state_q)
        ST_EMPTY, ST_READY: begin
          w_d[0]  = wload_data;
          count_d = 4'd1;
          state_d = ST_LOADING;
        end
        ST_LOADING: begin
          if (count_q == 4'(NUM_PIX)) begin
            bias_d  = wload_data;
            state_d = ST_READY;
          end else begin
            for (int i = 0; i < NUM_PIX; i++) begin
              if (count_q == 4'(i)) w_d[i] = wload_data;
            end
          end
          count_d = count_q + 4'd1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Pipeline datapath. The bias travels with stage 1 so a window in flight
  // finishes with the weight set it was accepted under, even across a reload.
  always_comb begin
    for (int i = 0; i < NUM_PIX; i++) begin
      prod_d[i] = 17'($signed({1'b0, pix[i]})) * 17'(w_q[i]);
    end
    bias1_d = bias_q;
    v1_d    = accept;

    sum_d = 21'(bias1_q);
    for (int i = 0; i < NUM_PIX; i++) begin
      sum_d = sum_d + 21'(prod_q[i]);
    end
    v2_d = v1_q;

    shifted     = sum_q >>> SHIFT;
    pixel_out_d = 8'd0;
    if (v2_q && !sum_q[20]) begin
      pixel_out_d = (shifted > 21'sd255) ? 8'd255 : shifted[7:0];
    end
    valid_out_d = v2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      count_q     <= '0;
      bias_q      <= '0;
      bias1_q     <= '0;
      v1_q        <= 1'b0;
      sum_q       <= '0;
      v2_q        <= 1'b0;
      pixel_out_q <= '0;
      valid_out_q <= 1'b0;
      for (int i = 0; i < NUM_PIX; i++) begin
        w_q[i]    <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      bias_q      <= bias_d;
      bias1_q     <= bias1_d;
      v1_q        <= v1_d;
      sum_q       <= sum_d;
      v2_q        <= v2_d;
      pixel_out_q <= pixel_out_d;
      valid_out_q <= valid_out_d;
      for (int i = 0; i < NUM_PIX; i++) begin
        w_q[i]    <= w_d[i];
        prod_q[i] <= prod_d[i];
      end
    end
  end

endmodule
